// File: rtl/regfile_scoreboard_if.sv
// Bundle between the pipeline (WB writeback, ID reads/issue) and the register file scoreboard.
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_scoreboard_if #(
  parameter int REG_LEN      = 32,
  parameter int REG_ADDR_LEN = 5
);
  logic [REG_LEN-1:0]      wb_rd_data;
  logic [REG_ADDR_LEN-1:0] wb_rd_addr;
  logic                    wb_rd_enable;
  logic                    id_rs1_read;
  logic [REG_ADDR_LEN-1:0] id_rs1_addr;
  logic                    id_rs2_read;
  logic [REG_ADDR_LEN-1:0] id_rs2_addr;
  logic                    issue_valid;
  logic [REG_ADDR_LEN-1:0] issue_rd_addr;
  logic [REG_LEN-1:0]      rs1_data;
  logic [REG_LEN-1:0]      rs2_data;
  logic                    stall_req;

  modport master (
    output wb_rd_data, wb_rd_addr, wb_rd_enable,
    output id_rs1_read, id_rs1_addr, id_rs2_read, id_rs2_addr,
    output issue_valid, issue_rd_addr,
    input  rs1_data, rs2_data, stall_req
  );

  modport slave (
    input  wb_rd_data, wb_rd_addr, wb_rd_enable,
    input  id_rs1_read, id_rs1_addr, id_rs2_read, id_rs2_addr,
    input  issue_valid, issue_rd_addr,
    output rs1_data, rs2_data, stall_req
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass and per-register pending-write
// counters that raise a stall to ID while an operand is still in flight.
module regfile_scoreboard #(
  parameter int REG_LEN      = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int CNT_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_scoreboard_if.slave   bus
);
  localparam int NUM_REGS = 1 << REG_ADDR_LEN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REG_LEN-1:0] r_regs [NUM_REGS];
  logic [CNT_W-1:0]   r_cnt  [NUM_REGS];

  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic                w_rs1_hazard;
  logic                w_rs2_hazard;
  logic                w_cap_hazard;
  logic                w_stall;

  // Per-register decode of issue and writeback hits; x0 never tracks anything.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
      if (gi == 0) begin : g_zero
        assign w_inc[gi] = 1'b0;
        assign w_dec[gi] = 1'b0;
      end else begin : g_reg
        assign w_inc[gi] = bus.issue_valid && !w_stall &&
                           (bus.issue_rd_addr == REG_ADDR_LEN'(gi));
        assign w_dec[gi] = bus.wb_rd_enable && (r_cnt[gi] != '0) &&
                           (bus.wb_rd_addr == REG_ADDR_LEN'(gi));
      end
    end
  endgenerate

  // A same-cycle WB retires one pending write, so only cnt-dec matters for the hazard.
  always_comb begin
    w_rs1_hazard = bus.id_rs1_read && (bus.id_rs1_addr != '0) &&
                   ((r_cnt[bus.id_rs1_addr] - CNT_W'(w_dec[bus.id_rs1_addr])) != '0);
    w_rs2_hazard = bus.id_rs2_read && (bus.id_rs2_addr != '0) &&
                   ((r_cnt[bus.id_rs2_addr] - CNT_W'(w_dec[bus.id_rs2_addr])) != '0);
    w_cap_hazard = bus.issue_valid && (bus.issue_rd_addr != '0) &&
                   (r_cnt[bus.issue_rd_addr] == CNT_MAX) && !w_dec[bus.issue_rd_addr];
    w_stall      = w_rs1_hazard || w_rs2_hazard || w_cap_hazard;
  end

  always_comb begin
    bus.rs1_data = r_regs[bus.id_rs1_addr];
    if (bus.id_rs1_addr == '0)
      bus.rs1_data = '0;
    else if (bus.wb_rd_enable && (bus.wb_rd_addr == bus.id_rs1_addr))
      bus.rs1_data = bus.wb_rd_data;

    bus.rs2_data = r_regs[bus.id_rs2_addr];
    if (bus.id_rs2_addr == '0)
      bus.rs2_data = '0;
    else if (bus.wb_rd_enable && (bus.wb_rd_addr == bus.id_rs2_addr))
      bus.rs2_data = bus.wb_rd_data;

    bus.stall_req = w_stall;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      if (bus.wb_rd_enable && (bus.wb_rd_addr != '0))
        r_regs[bus.wb_rd_addr] <= bus.wb_rd_data;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i])
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, x0 handling, pending counters,
// capacity stall and asynchronous reset, all against hand-computed values.
module tb_regfile_scoreboard;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  regfile_scoreboard_if #(.REG_LEN(32), .REG_ADDR_LEN(5)) bus ();

  regfile_scoreboard #(.REG_LEN(32), .REG_ADDR_LEN(5), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got 0x%08h", tag, got);
    end else begin
      $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wb_rd_data    = '0;
    bus.wb_rd_addr    = '0;
    bus.wb_rd_enable  = 1'b0;
    bus.id_rs1_read   = 1'b0;
    bus.id_rs1_addr   = '0;
    bus.id_rs2_read   = 1'b0;
    bus.id_rs2_addr   = '0;
    bus.issue_valid   = 1'b0;
    bus.issue_rd_addr = '0;
  endtask

  // Advance past the next rising edge; inputs are changed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_rd_enable = 1'b1;
    bus.wb_rd_addr   = a;
    bus.wb_rd_data   = d;
  endtask

  task automatic rd1(input logic [4:0] a);
    bus.id_rs1_read = 1'b1;
    bus.id_rs1_addr = a;
  endtask

  task automatic rd2(input logic [4:0] a);
    bus.id_rs2_read = 1'b1;
    bus.id_rs2_addr = a;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.issue_valid   = 1'b1;
    bus.issue_rd_addr = a;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    idle();
    repeat (2) tick();

    // Outputs while held in reset
    rd1(5'd5); rd2(5'd0); #1;
    chk("rst_rs1", bus.rs1_data, 32'h0);
    chk("rst_rs2", bus.rs2_data, 32'h0);
    chk("rst_stall", 32'(bus.stall_req), 32'h0);
    rst = 1'b1;
    tick();

    // x0 writes are dropped, including on the bypass path
    idle(); wb(5'd0, 32'hDEADBEEF); rd1(5'd0); #1;
    chk("x0_bypass", bus.rs1_data, 32'h0);
    tick();
    idle(); rd1(5'd0); #1;
    chk("x0_array", bus.rs1_data, 32'h0);

    // Bypass then array read of x3, both ports on the same address
    idle(); wb(5'd3, 32'h12345678); rd1(5'd3); #1;
    chk("x3_bypass", bus.rs1_data, 32'h12345678);
    chk("x3_stall", 32'(bus.stall_req), 32'h0);
    tick();
    idle(); rd1(5'd3); rd2(5'd3); #1;
    chk("x3_arr_rs1", bus.rs1_data, 32'h12345678);
    chk("x3_arr_rs2", bus.rs2_data, 32'h12345678);

    // Single pending write to x7
    idle(); issue(5'd7); #1;
    chk("x7_issue", 32'(bus.stall_req), 32'h0);
    tick();
    idle(); rd2(5'd7); #1;
    chk("x7_pending", 32'(bus.stall_req), 32'h1);
    wb(5'd7, 32'hA5A5A5A5); #1;
    chk("x7_wb_stall", 32'(bus.stall_req), 32'h0);
    chk("x7_wb_data", bus.rs2_data, 32'hA5A5A5A5);
    tick();
    idle(); rd2(5'd7); #1;
    chk("x7_cleared", 32'(bus.stall_req), 32'h0);
    chk("x7_array", bus.rs2_data, 32'hA5A5A5A5);

    // Two pending writes to x4: the older WB must not release the stall
    idle(); issue(5'd4); tick();
    idle(); issue(5'd4); tick();
    idle(); rd1(5'd4); #1;
    chk("x4_cnt2", 32'(bus.stall_req), 32'h1);
    wb(5'd4, 32'h1); #1;
    chk("x4_wb1", 32'(bus.stall_req), 32'h1);
    tick();
    idle(); rd1(5'd4); wb(5'd4, 32'h2); #1;
    chk("x4_wb2_stall", 32'(bus.stall_req), 32'h0);
    chk("x4_wb2_data", bus.rs1_data, 32'h2);
    tick();
    idle(); rd1(5'd4); #1;
    chk("x4_cleared", 32'(bus.stall_req), 32'h0);

    // Issue while stalled must not increment the destination counter
    idle(); issue(5'd6); tick();
    idle(); rd1(5'd6); issue(5'd5); #1;
    chk("ign_stall", 32'(bus.stall_req), 32'h1);
    tick();
    idle(); rd1(5'd5); #1;
    chk("ign_no_inc", 32'(bus.stall_req), 32'h0);
    idle(); wb(5'd6, 32'h66); tick();

    // Fill x9 to capacity (3), then probe the capacity stall
    for (int k = 0; k < 3; k++) begin
      idle(); issue(5'd9); tick();
    end
    idle(); issue(5'd9); #1;
    chk("cap_stall", 32'(bus.stall_req), 32'h1);
    tick();
    idle(); issue(5'd9); wb(5'd9, 32'h99); #1;
    chk("cap_wb_ok", 32'(bus.stall_req), 32'h0);
    tick();
    // Drain: counter must still be 3, so only the third WB releases rs1
    idle(); rd1(5'd9); wb(5'd9, 32'h91); #1;
    chk("drain3", 32'(bus.stall_req), 32'h1);
    tick();
    idle(); rd1(5'd9); wb(5'd9, 32'h92); #1;
    chk("drain2", 32'(bus.stall_req), 32'h1);
    tick();
    idle(); rd1(5'd9); wb(5'd9, 32'h93); #1;
    chk("drain1", 32'(bus.stall_req), 32'h0);
    chk("drain1_data", bus.rs1_data, 32'h93);
    tick();
    idle(); rd1(5'd9); #1;
    chk("drain0", 32'(bus.stall_req), 32'h0);

    // Asynchronous reset mid-cycle discards pending state and register contents
    idle(); issue(5'd2); tick();
    idle(); rd1(5'd2); rd2(5'd3); #1;
    chk("pre_rst_stall", 32'(bus.stall_req), 32'h1);
    chk("pre_rst_x3", bus.rs2_data, 32'h12345678);
    #1 rst = 1'b0;
    #1;
    chk("rst_now_stall", 32'(bus.stall_req), 32'h0);
    chk("rst_now_x3", bus.rs2_data, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    idle(); rd1(5'd2); #1;
    chk("post_rst_stall", 32'(bus.stall_req), 32'h0);
    chk("post_rst_data", bus.rs1_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
